// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: qualifies the ioctl byte stream, forwards
// in-range writes with a one-hot region select, verifies the image
// sizes and holds the CPUs in reset until both images are valid.
module rom_dl_sequencer #(
  parameter logic [24:0] MAIN_SIZE = 25'hA000,
  parameter logic [24:0] SND_SIZE  = 25'h2000,
  parameter logic [7:0]  MAIN_IDX  = 8'd0,
  parameter logic [7:0]  SND_IDX   = 8'd1
) (
  input  logic        CLK_DL,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [9:0]  main_cs,
  output logic [1:0]  snd_cs,
  output logic        main_loaded,
  output logic        snd_loaded,
  output logic [1:0]  rom_error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_MAIN = 3'd1,
    LOAD_SND  = 3'd2,
    CHECK     = 3'd3,
    SKIP      = 3'd4
  } state_t;

  state_t      state_r, state_nx;
  logic        dl_q_r;
  logic        armed_r;     // download seen low since reset: only a fresh edge starts a load
  logic        cur_snd_r, cur_snd_nx;
  logic [24:0] hw_r, hw_nx;
  logic        ovf_r, ovf_nx;
  logic [24:0] dl_addr_r, dl_addr_nx;
  logic [7:0]  dl_data_r, dl_data_nx;
  logic        dl_wr_r, dl_wr_nx;
  logic [9:0]  main_cs_r, main_cs_nx;
  logic [1:0]  snd_cs_r, snd_cs_nx;
  logic        main_loaded_r, main_loaded_nx;
  logic        snd_loaded_r, snd_loaded_nx;
  logic [1:0]  rom_error_r, rom_error_nx;
  logic        cpu_hold_r, cpu_hold_nx;

  logic        rise_s, fall_s;
  logic [24:0] addr_p1_s;
  logic [12:0] region_s;

  assign rise_s    = ioctl_download & ~dl_q_r & armed_r;
  assign fall_s    = ~ioctl_download & dl_q_r;
  assign addr_p1_s = ioctl_addr + 25'd1;
  assign region_s  = ioctl_addr[24:12];

  // Next-state, write qualification, size bookkeeping and hold request
  always_comb begin
    state_nx       = state_r;
    cur_snd_nx     = cur_snd_r;
    hw_nx          = hw_r;
    ovf_nx         = ovf_r;
    dl_addr_nx     = dl_addr_r;
    dl_data_nx     = dl_data_r;
    dl_wr_nx       = 1'b0;
    main_cs_nx     = 10'd0;
    snd_cs_nx      = 2'd0;
    main_loaded_nx = main_loaded_r;
    snd_loaded_nx  = snd_loaded_r;
    rom_error_nx   = rom_error_r;

    case (state_r)
      IDLE: begin
        if (rise_s) begin
          if (ioctl_index == MAIN_IDX) begin
            state_nx        = LOAD_MAIN;
            cur_snd_nx      = 1'b0;
            main_loaded_nx  = 1'b0;
            rom_error_nx[0] = 1'b0;
            hw_nx           = 25'd0;
            ovf_nx          = 1'b0;
          end else if (ioctl_index == SND_IDX) begin
            state_nx        = LOAD_SND;
            cur_snd_nx      = 1'b1;
            snd_loaded_nx   = 1'b0;
            rom_error_nx[1] = 1'b0;
            hw_nx           = 25'd0;
            ovf_nx          = 1'b0;
          end else begin
            state_nx = SKIP;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD_MAIN, LOAD_SND: begin
        if (ioctl_wr) begin
          if (ioctl_addr < ((state_r == LOAD_MAIN) ? MAIN_SIZE : SND_SIZE)) begin
            dl_wr_nx   = 1'b1;
            dl_addr_nx = ioctl_addr;
            dl_data_nx = ioctl_dout;
            if (state_r == LOAD_MAIN) begin
              main_cs_nx = 10'd1 << region_s;
            end else begin
              snd_cs_nx = 2'd1 << region_s;
            end
            if (addr_p1_s > hw_r) begin
              hw_nx = addr_p1_s;
            end else begin
              hw_nx = hw_r;
            end
          end else begin
            ovf_nx = 1'b1;
          end
        end else begin
          dl_wr_nx = 1'b0;
        end
        if (fall_s) begin
          state_nx = CHECK;
        end else begin
          state_nx = state_r;
        end
      end
      CHECK: begin
        if (cur_snd_r) begin
          if ((hw_r == SND_SIZE) && !ovf_r) begin
            snd_loaded_nx = 1'b1;
          end else begin
            rom_error_nx[1] = 1'b1;
          end
        end else begin
          if ((hw_r == MAIN_SIZE) && !ovf_r) begin
            main_loaded_nx = 1'b1;
          end else begin
            rom_error_nx[0] = 1'b1;
          end
        end
        state_nx = IDLE;
      end
      SKIP: begin
        if (fall_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = SKIP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    cpu_hold_nx = ~(main_loaded_nx & snd_loaded_nx) | (state_nx != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK_DL or posedge RESET) begin
    if (RESET) begin
      state_r       <= IDLE;
      dl_q_r        <= 1'b0;
      armed_r       <= 1'b0;
      cur_snd_r     <= 1'b0;
      hw_r          <= 25'd0;
      ovf_r         <= 1'b0;
      dl_addr_r     <= 25'd0;
      dl_data_r     <= 8'd0;
      dl_wr_r       <= 1'b0;
      main_cs_r     <= 10'd0;
      snd_cs_r      <= 2'd0;
      main_loaded_r <= 1'b0;
      snd_loaded_r  <= 1'b0;
      rom_error_r   <= 2'd0;
      cpu_hold_r    <= 1'b1;
    end else begin
      state_r       <= state_nx;
      dl_q_r        <= ioctl_download;
      armed_r       <= armed_r | ~ioctl_download;
      cur_snd_r     <= cur_snd_nx;
      hw_r          <= hw_nx;
      ovf_r         <= ovf_nx;
      dl_addr_r     <= dl_addr_nx;
      dl_data_r     <= dl_data_nx;
      dl_wr_r       <= dl_wr_nx;
      main_cs_r     <= main_cs_nx;
      snd_cs_r      <= snd_cs_nx;
      main_loaded_r <= main_loaded_nx;
      snd_loaded_r  <= snd_loaded_nx;
      rom_error_r   <= rom_error_nx;
      cpu_hold_r    <= cpu_hold_nx;
    end
  end

  assign dl_addr     = dl_addr_r;
  assign dl_data     = dl_data_r;
  assign dl_wr       = dl_wr_r;
  assign main_cs     = main_cs_r;
  assign snd_cs      = snd_cs_r;
  assign main_loaded = main_loaded_r;
  assign snd_loaded  = snd_loaded_r;
  assign rom_error   = rom_error_r;
  assign cpu_hold    = cpu_hold_r;

endmodule
